dffram_init_rw: RTL and testbench

Parametrised single-port flip-flop RAM with per-byte write enables, a registered read port with valid strobe, and a hardware clear engine that zero-fills the array after reset or on command. It is the next-generation macro for the DFF-based memory family: word width, depth and clear behaviour are parameters, and it adds a busy/valid handshake. It sits directly under SoC scratchpads and register files that need a known-zero memory after reset.

---
 rtl/dffram_init_rw_pkg.sv | 23 ++
 rtl/dffram_init_rw_word.sv | 23 ++
 rtl/dffram_init_rw.sv | 111 +++++++++++
 tb/tb_dffram_init_rw.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dffram_init_rw_pkg.sv
// Shared types and helpers for the DFF RAM with hardware clear engine.
//   state_t      : controller state (IDLE / CLEARING)
//   BYTE_W       : bits per byte lane
//   dffram_merge : byte-lane merge, returns the new byte where enabled else the old one
package dffram_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    // Applied lane by lane so it works for any word width.
    function automatic logic [BYTE_W-1:0] dffram_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/dffram_init_rw_word.sv
// One RAM word built from flip-flops, with per-byte write enables.
//   clk : clock
//   we  : byte write enables (WSIZE bits)
//   d   : write data
//   q   : stored word (not reset)
module dffram_word
    import dffram_pkg::*;
#(
    parameter int WSIZE = 4
) (
    input  logic                      clk,
    input  logic [WSIZE-1:0]          we,
    input  logic [BYTE_W*WSIZE-1:0]   d,
    output logic [BYTE_W*WSIZE-1:0]   q
);

    always_ff @(posedge clk) begin
        for (int b = 0; b < WSIZE; b++) begin
            if (we[b]) q[b*BYTE_W +: BYTE_W] <= d[b*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/dffram_init_rw.sv
// Single-port DFF RAM with byte enables, registered read port with valid
// strobe, and a zero-fill engine that runs after reset and on CLR.
//   CLK, RST : clock, asynchronous active-high reset
//   EN0      : access request (ignored while BUSY)
//   WE0      : byte write enables, any bit set makes the access a write
//   A0, Di0  : word address, write data
//   CLR      : start a zero-fill (ignored while BUSY)
//   Do0      : registered read / write-through data
//   DoV0     : one-cycle strobe, Do0 updated
//   BUSY     : zero-fill in progress
module dffram_init_rw
    import dffram_pkg::*;
#(
    parameter int WSIZE          = 4,
    parameter int AW             = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN0,
    input  logic [WSIZE-1:0]        WE0,
    input  logic [AW-1:0]           A0,
    input  logic [BYTE_W*WSIZE-1:0] Di0,
    input  logic                    CLR,
    output logic [BYTE_W*WSIZE-1:0] Do0,
    output logic                    DoV0,
    output logic                    BUSY
);

    localparam int          DEPTH = 2**AW;
    localparam int          DW    = BYTE_W*WSIZE;
    // Counter is one bit wider than the address so it can never alias back to 0.
    localparam logic [AW:0] LAST  = (AW+1)'(DEPTH-1);

    state_t                    state;
    logic [AW:0]               cnt;
    logic [DEPTH-1:0][DW-1:0]  words;
    logic [DW-1:0]             rd_word;
    logic [DW-1:0]             merged;
    logic [DW-1:0]             wr_data;
    logic                      access;

    assign access  = (state == IDLE) && EN0;
    assign rd_word = words[A0];
    // The clear engine owns the write bus while clearing.
    assign wr_data = (state == CLEARING) ? '0 : Di0;

    // Write-through value: the word as it will look after this write.
    always_comb begin
        merged = '0;
        for (int b = 0; b < WSIZE; b++) begin
            merged[b*BYTE_W +: BYTE_W] = dffram_merge(rd_word[b*BYTE_W +: BYTE_W],
                                                      Di0[b*BYTE_W +: BYTE_W], WE0[b]);
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_word
        logic [WSIZE-1:0] we_j;

        always_comb begin
            we_j = '0;
            if (state == CLEARING) begin
                if (cnt == (AW+1)'(j)) we_j = '1;
            end else if (access && (A0 == AW'(j))) begin
                we_j = WE0;
            end
        end

        dffram_word #(.WSIZE(WSIZE)) u_word (
            .clk (CLK),
            .we  (we_j),
            .d   (wr_data),
            .q   (words[j])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR_ON_RESET ? CLEARING : IDLE;
            BUSY  <= CLEAR_ON_RESET;
            cnt   <= '0;
            Do0   <= '0;
            DoV0  <= 1'b0;
        end else begin
            case (state)
                CLEARING: begin
                    DoV0 <= 1'b0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    DoV0 <= EN0;
                    if (EN0) Do0 <= merged;
                    // An access in the same cycle completes first; the clear
                    // then overwrites it.
                    if (CLR) begin
                        state <= CLEARING;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_init_rw.sv
// Scoreboard bench for dffram_init_rw: two instances (clear-on-reset on/off),
// directed requests push expected Do0 values, monitors pop on DoV0.
module tb_dffram_init_rw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, clr_a, dov_a, busy_a;
    logic [3:0]  we_a, a_a;
    logic [31:0] d_a, do_a;
    logic        rst_b, en_b, clr_b, dov_b, busy_b;
    logic [3:0]  we_b, a_b;
    logic [31:0] d_b, do_b;

    dffram_init_rw #(.WSIZE(4), .AW(4), .CLEAR_ON_RESET(1'b1)) dut_a (
        .CLK(clk), .RST(rst_a), .EN0(en_a), .WE0(we_a), .A0(a_a), .Di0(d_a),
        .CLR(clr_a), .Do0(do_a), .DoV0(dov_a), .BUSY(busy_a)
    );

    dffram_init_rw #(.WSIZE(4), .AW(4), .CLEAR_ON_RESET(1'b0)) dut_b (
        .CLK(clk), .RST(rst_b), .EN0(en_b), .WE0(we_b), .A0(a_b), .Di0(d_b),
        .CLR(clr_b), .Do0(do_b), .DoV0(dov_b), .BUSY(busy_b)
    );

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DoV0 high with nothing expected", nm);
    endtask

    // Monitors: compare whenever a DUT strobes DoV0.
    always @(negedge clk) begin
        if (!rst_a && dov_a) begin
            if (exp_a.size() == 0) unexpected("dov_a");
            else chk("rd_a", do_a, exp_a.pop_front());
        end
        if (!rst_b && dov_b) begin
            if (exp_b.size() == 0) unexpected("dov_b");
            else chk("rd_b", do_b, exp_b.pop_front());
        end
    end

    task automatic acc(input bit sel, input bit en, input bit clr, input logic [3:0] we,
                       input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        if (sel) begin
            en_b = en; clr_b = clr; we_b = we; a_b = a; d_b = d;
            if (en) exp_b.push_back(exp);
        end else begin
            en_a = en; clr_a = clr; we_a = we; a_a = a; d_a = d;
            if (en) exp_a.push_back(exp);
        end
    endtask

    task automatic idle(input bit sel);
        @(negedge clk);
        if (sel) begin en_b = 1'b0; clr_b = 1'b0; end
        else begin en_a = 1'b0; clr_a = 1'b0; end
    endtask

    // Counts negedges with BUSY high; optionally pokes a write mid-clear that must vanish.
    task automatic count_busy(input bit sel, input bit poke);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 100) begin
            n++;
            if (poke && n == 3) begin
                en_a = 1'b1; we_a = 4'hF; a_a = 4'd5; d_a = 32'hCAFEF00D; clr_a = 1'b1;
            end
            if (n == 4) begin en_a = 1'b0; clr_a = 1'b0; end
            @(negedge clk);
        end
        en_a = 1'b0; clr_a = 1'b0;
        chk(sel ? "busy_len_b" : "busy_len_a", n, 16);
    endtask

    task automatic read_all_zero(input bit sel);
        for (int i = 0; i < 16; i++) acc(sel, 1, 0, 4'h0, i[3:0], 32'h0, 32'h0);
        idle(sel);
    endtask

    task automatic fill_ones;
        for (int i = 0; i < 16; i++) acc(0, 1, 0, 4'hF, i[3:0], 32'hFFFFFFFF, 32'hFFFFFFFF);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; we_a = '0; a_a = '0; d_a = '0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; we_b = '0; a_b = '0; d_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_do_a", do_a, 32'h0);
        chk("rst_dov_a", {31'h0, dov_a}, 32'h0);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h1);
        chk("rst_busy_b", {31'h0, busy_b}, 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        count_busy(0, 0);
        chk("busy_b_after_rst", {31'h0, busy_b}, 32'h0);
        read_all_zero(0);

        // Partial writes and write-through
        acc(0, 1, 0, 4'b0101, 4'd3, 32'hAABBCCDD, 32'h00BB00DD);
        acc(0, 1, 0, 4'b0000, 4'd3, 32'h0,        32'h00BB00DD);
        acc(0, 1, 0, 4'b1010, 4'd3, 32'h11223344, 32'h11BB33DD);
        acc(0, 1, 0, 4'hF,    4'd7, 32'h12345678, 32'h12345678);
        acc(0, 1, 0, 4'h0,    4'd7, 32'h0,        32'h12345678);
        acc(0, 1, 0, 4'h0,    4'd3, 32'h0,        32'h11BB33DD);
        idle(0);

        // Runtime clear together with a write; a write during BUSY must vanish
        fill_ones();
        acc(0, 1, 1, 4'hF, 4'd2, 32'h00000055, 32'h00000055);
        idle(0);
        count_busy(0, 1);
        read_all_zero(0);

        // Reset in the middle of a clear
        fill_ones();
        acc(0, 0, 1, 4'h0, 4'd0, 32'h0, 32'h0);
        idle(0);
        repeat (4) @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("midrst_do_a", do_a, 32'h0);
        chk("midrst_dov_a", {31'h0, dov_a}, 32'h0);
        chk("midrst_busy_a", {31'h0, busy_a}, 32'h1);
        @(negedge clk);
        rst_a = 1'b0;
        count_busy(0, 0);
        read_all_zero(0);

        // No clear after reset: plain write/read, then CLR still works
        acc(1, 1, 0, 4'hF, 4'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        acc(1, 1, 0, 4'h0, 4'd0, 32'h0,        32'hDEADBEEF);
        acc(1, 0, 1, 4'h0, 4'd0, 32'h0,        32'h0);
        idle(1);
        count_busy(1, 0);
        read_all_zero(1);

        repeat (3) @(negedge clk);
        chk("queue_a_drained", exp_a.size(), 32'h0);
        chk("queue_b_drained", exp_b.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
